// File: rtl/bcd2bin_seq_if.sv
// Handshake bundle between the BCD entry logic (master) and the
// sequential BCD-to-binary converter (slave).
interface bcd2bin_seq_if #(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 14
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [OUT_W-1:0]      bin_out;
  logic                  err;

  modport master (
    output start,
    output bcd_in,
    input  busy,
    input  done,
    input  bin_out,
    input  err
  );

  modport slave (
    input  start,
    input  bcd_in,
    output busy,
    output done,
    output bin_out,
    output err
  );
endinterface

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter: folds one BCD digit per clock,
// most significant first, with acc = acc*10 + digit (shift-add, no multiplier).
module bcd2bin_seq #(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 14
) (
  input  logic              clk,
  input  logic              rst,
  bcd2bin_seq_if.slave      bus
);

  localparam int SR_W  = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

  generate
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $error("bcd2bin_seq: DIGITS must be in 1..8");
    end
  endgenerate

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic [OUT_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_acc_q, err_acc_d;
  logic [OUT_W-1:0]    bin_q, bin_d;
  logic                err_q, err_d;
  logic                done_q, done_d;

  logic [3:0]          digit;
  logic [OUT_W-1:0]    acc_next;
  logic                err_next;

  // x*10 as (x<<3)+(x<<1); the result wraps modulo 2^OUT_W.
  function automatic logic [OUT_W-1:0] mul10(input logic [OUT_W-1:0] x);
    mul10 = (x << 3) + (x << 1);
  endfunction

  function automatic logic [OUT_W-1:0] fold_digit(input logic [OUT_W-1:0] a,
                                                  input logic [3:0]       d);
    fold_digit = mul10(a) + OUT_W'(d);
  endfunction

  always_comb begin
    digit    = sr_q[SR_W-1 -: 4];
    acc_next = fold_digit(acc_q, digit);
    err_next = err_acc_q | (digit > 4'd9);
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    err_acc_d = err_acc_q;
    bin_d     = bin_q;
    err_d     = err_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sr_d      = bus.bcd_in;
          acc_d     = '0;
          cnt_d     = '0;
          err_acc_d = 1'b0;
          state_d   = S_CONV;
        end
      end
      S_CONV: begin
        acc_d     = acc_next;
        err_acc_d = err_next;
        sr_d      = sr_q << 4;
        cnt_d     = cnt_q + CNT_W'(1);
        // Last digit: publish the result directly from the fold, not from acc_q.
        if (cnt_q == CNT_LAST) begin
          bin_d   = acc_next;
          err_d   = err_next;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sr_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_acc_q <= 1'b0;
      bin_q     <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      err_acc_q <= err_acc_d;
      bin_q     <= bin_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = (state_q == S_CONV);
  assign bus.done    = done_q;
  assign bus.bin_out = bin_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Scoreboard bench for bcd2bin_seq: a DIGITS=4 instance driven by directed and
// random conversions, plus a DIGITS=2/OUT_W=7 instance.
module tb_bcd2bin_seq;
  localparam int DIGITS = 4;
  localparam int OUT_W  = 14;
  localparam int D2     = 2;
  localparam int W2     = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd2bin_seq_if #(.DIGITS(DIGITS), .OUT_W(OUT_W)) bus ();
  bcd2bin_seq_if #(.DIGITS(D2),     .OUT_W(W2))    bus2 ();

  bcd2bin_seq #(.DIGITS(DIGITS), .OUT_W(OUT_W)) dut  (.clk(clk), .rst(rst), .bus(bus));
  bcd2bin_seq #(.DIGITS(D2),     .OUT_W(W2))    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    longint val;
    bit     err;
    int     due;
  } exp_t;

  exp_t   q[$];
  int     cyc      = 0;
  int     free_at  = 0;
  longint hold_bin = 0;
  bit     hold_err = 1'b0;
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: decimal value of the digit string, wrapped to ow bits.
  function automatic void ref_conv(input longint w, input int nd, input int ow,
                                   output longint v, output bit e);
    v = 0;
    e = 1'b0;
    for (int i = nd - 1; i >= 0; i--) begin
      longint d;
      d = (w >> (4 * i)) & 15;
      v = v * 10 + d;
      if (d > 9) e = 1'b1;
    end
    v = v % (longint'(1) << ow);
  endfunction

  function automatic longint rand_word(input int nd);
    longint w;
    w = 0;
    for (int i = 0; i < nd; i++) begin
      longint d;
      d = ($urandom_range(0, 7) == 0) ? longint'($urandom_range(10, 15))
                                      : longint'($urandom_range(0, 9));
      w = (w << 4) | d;
    end
    return w;
  endfunction

  // Issue model: a start seen at an edge while the converter is free is
  // accepted; it is busy for DIGITS edges and reports after the last one.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst && bus.start && cyc >= free_at) begin
      longint v;
      bit     e;
      ref_conv(longint'(bus.bcd_in), DIGITS, OUT_W, v, e);
      q.push_back('{val: v, err: e, due: cyc + DIGITS});
      free_at = cyc + DIGITS + 1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_busy", longint'(bus.busy), 0);
      chk("rst_done", longint'(bus.done), 0);
      chk("rst_bin",  longint'(bus.bin_out), 0);
      chk("rst_err",  longint'(bus.err), 0);
    end else if (bus.done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("bin_out", longint'(bus.bin_out), x.val);
        chk("err", longint'(bus.err), longint'(x.err));
        chk("done_cycle", longint'(cyc), longint'(x.due));
        chk("busy_at_done", longint'(bus.busy), 0);
        hold_bin = x.val;
        hold_err = x.err;
      end
    end else begin
      chk("bin_hold", longint'(bus.bin_out), hold_bin);
      chk("err_hold", longint'(bus.err), longint'(hold_err));
      if (q.size() > 0 && cyc > q[0].due) begin
        chk("done_seen", 0, 1);
        void'(q.pop_front());
      end
      chk("busy", longint'(bus.busy), longint'(q.size() > 0 && cyc < q[0].due));
    end
  end

  task automatic issue(input logic [4*DIGITS-1:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("busy_timeout", 1, 0);
    bus.bcd_in = w;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic run_small(input logic [4*D2-1:0] w);
    int     acc_cyc;
    int     n;
    longint v;
    bit     e;
    ref_conv(longint'(w), D2, W2, v, e);
    @(negedge clk);
    bus2.bcd_in = w;
    bus2.start  = 1'b1;
    acc_cyc     = cyc + 1;
    @(negedge clk);
    bus2.start  = 1'b0;
    n = 0;
    while (!bus2.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("small_done", longint'(bus2.done), 1);
    chk("small_latency", longint'(cyc - acc_cyc), D2);
    chk("small_bin", longint'(bus2.bin_out), v);
    chk("small_err", longint'(bus2.err), longint'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.bcd_in  = '0;
    bus2.start  = 1'b0;
    bus2.bcd_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue(16'h1234); wait_idle();
    chk("bin_1234", longint'(bus.bin_out), 1234);
    issue(16'h9999); wait_idle();
    chk("bin_9999", longint'(bus.bin_out), 9999);
    issue(16'h0000); wait_idle();
    chk("bin_0", longint'(bus.bin_out), 0);
    issue(16'h000A); wait_idle();
    chk("bin_10", longint'(bus.bin_out), 10);
    chk("err_10", longint'(bus.err), 1);
    issue(16'h0042); wait_idle();
    chk("bin_42", longint'(bus.bin_out), 42);
    chk("err_42", longint'(bus.err), 0);

    // start held high; bcd_in changed while busy
    @(negedge clk);
    bus.bcd_in = 16'h0005;
    bus.start  = 1'b1;
    repeat (2) @(negedge clk);
    bus.bcd_in = 16'h0007;
    repeat (4) @(negedge clk);
    bus.start  = 1'b0;
    wait_idle();
    chk("bin_held_start", longint'(bus.bin_out), 7);

    // asynchronous reset in the middle of a conversion
    issue(16'h5678);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    q.delete();
    free_at  = 0;
    hold_bin = 0;
    hold_err = 1'b0;
    #1;
    chk("async_busy", longint'(bus.busy), 0);
    chk("async_bin",  longint'(bus.bin_out), 0);
    chk("async_done", longint'(bus.done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(16'h0321); wait_idle();
    chk("bin_321", longint'(bus.bin_out), 321);

    for (int i = 0; i < 40; i++) begin
      issue(16'(rand_word(DIGITS)));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    wait_idle();

    run_small(8'h99);
    run_small(8'h07);
    for (int i = 0; i < 6; i++) run_small(8'(rand_word(D2)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
